// File: rtl/alu_pipe_pkg.sv
// rtl/alu_pipe_pkg.sv - shared types for the pipelined VeriRISC ALU
package alu_pipe_pkg;

  // Legacy VeriRISC opcode encoding; all eight codes are defined.
  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;

  // Status flags that travel with each result beat.
  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
  } alu_flags_t;

  localparam alu_flags_t FLAGS_CLEAR = '0;

endpackage

// File: rtl/alu_pipe_stage.sv
// rtl/alu_pipe_stage.sv - one valid/ready register slice holding {result, flags}
module alu_pipe_stage
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic             ready_i,
  input  logic [WIDTH-1:0] res_i,
  input  alu_flags_t       flags_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] res_o,
  output alu_flags_t       flags_o
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] res_q, res_d;
  alu_flags_t       flags_q, flags_d;
  logic             open;

  // The slice can take a new beat when empty or when its current beat leaves.
  assign open = !vld_q || ready_i;

  // Next state: payload only changes on an actual load, so a stalled beat holds.
  always_comb begin
    vld_d   = vld_q;
    res_d   = res_q;
    flags_d = flags_q;
    if (open) begin
      vld_d = valid_i;
      if (valid_i) begin
        res_d   = res_i;
        flags_d = flags_i;
      end
    end
  end

  // State register; reset clears payload too so nothing is ever X.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= 1'b0;
      res_q   <= '0;
      flags_q <= FLAGS_CLEAR;
    end else begin
      vld_q   <= vld_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign valid_o = vld_q;
  assign res_o   = res_q;
  assign flags_o = flags_q;

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - pipelined VeriRISC ALU with valid/ready handshake
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8,  // legal 4..32
  parameter int PIPE  = 2   // legal 1..4, equals latency in cycles
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  opcode_t          opcode,
  input  logic [WIDTH-1:0] accum,
  input  logic [WIDTH-1:0] data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output alu_flags_t       flags
);

  // Index 0 is the combinational compute result; index k is slice k's output.
  logic [PIPE:0]    vld;
  logic [PIPE:0]    rdy;
  logic [WIDTH-1:0] res [PIPE+1];
  alu_flags_t       flg [PIPE+1];

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_c;
  alu_flags_t       flags_c;

  // Operation and flag compute; zero follows the legacy ALU and looks at accum.
  always_comb begin
    sum     = {1'b0, accum} + {1'b0, data};
    res_c   = accum;
    flags_c = FLAGS_CLEAR;
    case (opcode)
      OP_ADD:                         res_c = sum[WIDTH-1:0];
      OP_AND:                         res_c = accum & data;
      OP_XOR:                         res_c = accum ^ data;
      OP_LDA:                         res_c = data;
      OP_HLT, OP_SKZ, OP_STO, OP_JMP: res_c = accum;
      default:                        res_c = accum;
    endcase
    flags_c.zero = (accum == '0);
    flags_c.neg  = res_c[WIDTH-1];
    if (opcode == OP_ADD) begin
      flags_c.carry = sum[WIDTH];
      flags_c.ovf   = (accum[WIDTH-1] == data[WIDTH-1]) &&
                      (sum[WIDTH-1] != accum[WIDTH-1]);
    end
  end

  // Ready ripples back from the consumer: a slice is open if empty or draining.
  always_comb begin
    rdy       = '0;
    rdy[PIPE] = out_ready;
    for (int k = PIPE - 1; k >= 0; k--) begin
      rdy[k] = !vld[k+1] || rdy[k+1];
    end
  end

  assign vld[0]   = in_valid;
  assign res[0]   = res_c;
  assign flg[0]   = flags_c;
  assign in_ready = rdy[0] && !rst;

  for (genvar g = 0; g < PIPE; g++) begin : g_stage
    alu_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .valid_i (vld[g]),
      .ready_i (rdy[g+1]),
      .res_i   (res[g]),
      .flags_i (flg[g]),
      .valid_o (vld[g+1]),
      .res_o   (res[g+1]),
      .flags_o (flg[g+1])
    );
  end

  assign out_valid = vld[PIPE];
  assign out       = res[PIPE];
  assign flags     = flg[PIPE];

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed and scoreboard bench for alu_pipe
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  opcode_t    opcode = OP_HLT;
  logic [7:0] accum = 8'h00;
  logic [7:0] data = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out;
  alu_flags_t flags;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8), .PIPE(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .accum     (accum),
    .data      (data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flags     (flags)
  );

  // Parameter sweep instances: each adds 2^(W-1)-1 + 1 when pulsed.
  logic        sw_valid = 1'b0;
  logic        sw_ov  [6];
  logic        sw_ir  [6];
  logic [31:0] sw_out [6];
  alu_flags_t  sw_fl  [6];

  for (genvar g = 0; g < 6; g++) begin : g_sw
    localparam int W = (g < 2) ? 4 : (g < 4) ? 16 : 32;
    localparam int P = (g % 2 == 0) ? 1 : 4;
    localparam logic [W-1:0] A_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] ONE = W'(1);
    logic [W-1:0] out_w;
    alu_flags_t   fl_w;
    logic         ov_w;
    logic         ir_w;
    alu_pipe #(.WIDTH(W), .PIPE(P)) u_sw (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (sw_valid),
      .in_ready  (ir_w),
      .opcode    (OP_ADD),
      .accum     (A_MAX),
      .data      (ONE),
      .out_valid (ov_w),
      .out_ready (1'b1),
      .out       (out_w),
      .flags     (fl_w)
    );
    assign sw_ov[g]  = ov_w;
    assign sw_ir[g]  = ir_w;
    assign sw_out[g] = 32'(out_w);
    assign sw_fl[g]  = fl_w;
  end

  function automatic logic [11:0] ref_beat(opcode_t op, logic [7:0] a, logic [7:0] d);
    int ua, ud, sa, sd;
    logic [7:0] r;
    logic z, n, c, v;
    ua = int'(a);
    ud = int'(d);
    sa = $signed(a);
    sd = $signed(d);
    case (op)
      OP_ADD:  r = 8'(ua + ud);
      OP_AND:  r = a & d;
      OP_XOR:  r = a ^ d;
      OP_LDA:  r = d;
      default: r = a;
    endcase
    z = (ua == 0);
    n = r[7];
    c = (op == OP_ADD) && (ua + ud > 255);
    v = (op == OP_ADD) && ((sa + sd > 127) || (sa + sd < -128));
    return {r, z, n, c, v};
  endfunction

  task automatic drive(input logic r, input logic v, input opcode_t op,
                       input logic [7:0] a, input logic [7:0] d, input logic ordy);
    @(posedge clk);
    #1;
    rst = r;
    in_valid = v;
    opcode = op;
    accum = a;
    data = d;
    out_ready = ordy;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int stale;
    drive(1'b1, 1'b0, OP_HLT, 8'h00, 8'h00, 1'b1);
    drive(1'b1, 1'b0, OP_HLT, 8'h00, 8'h00, 1'b1);
    total++;
    if ({out_valid, out, flags, in_ready} !== 14'h0) begin
      bad++;
      $display("FAIL reset_init: got v=%0b out=%h flags=%b rdy=%0b want all 0",
               out_valid, out, flags, in_ready);
    end
    drive(1'b0, 1'b1, OP_ADD, 8'h01, 8'h02, 1'b0);
    drive(1'b0, 1'b1, OP_ADD, 8'h03, 8'h04, 1'b0);
    drive(1'b1, 1'b1, OP_ADD, 8'h05, 8'h06, 1'b0);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_ready: got %0b want 0", in_ready);
    end
    drive(1'b1, 1'b0, OP_HLT, 8'h00, 8'h00, 1'b0);
    total++;
    if ({out_valid, out, flags, in_ready} !== 14'h0) begin
      bad++;
      $display("FAIL reset_mid: got v=%0b out=%h flags=%b rdy=%0b want all 0",
               out_valid, out, flags, in_ready);
    end
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, OP_HLT, 8'h00, 8'h00, 1'b1);
      if (out_valid) stale++;
    end
    total++;
    if (stale !== 0) begin
      bad++;
      $display("FAIL reset_stale: got %0d stale beats want 0", stale);
    end
  endtask

  task automatic test_add_ovf();
    drive(1'b0, 1'b1, OP_ADD, 8'h7F, 8'h01, 1'b1);
    drive(1'b0, 1'b0, OP_HLT, 8'h00, 8'h00, 1'b1);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL ovf_early: out_valid got %0b want 0 one cycle after accept", out_valid);
    end
    drive(1'b0, 1'b0, OP_HLT, 8'h00, 8'h00, 1'b1);
    total++;
    if ({out_valid, out, flags} !== {1'b1, 8'h80, 4'b0101}) begin
      bad++;
      $display("FAIL ovf_add: got v=%0b out=%h flags=%b want v=1 out=80 flags=0101",
               out_valid, out, flags);
    end
  endtask

  task automatic test_carry_lda();
    drive(1'b0, 1'b1, OP_ADD, 8'hFF, 8'h01, 1'b1);
    drive(1'b0, 1'b1, OP_LDA, 8'h00, 8'h5A, 1'b1);
    drive(1'b0, 1'b0, OP_HLT, 8'h00, 8'h00, 1'b1);
    total++;
    if ({out_valid, out, flags} !== {1'b1, 8'h00, 4'b0010}) begin
      bad++;
      $display("FAIL carry_add: got v=%0b out=%h flags=%b want v=1 out=00 flags=0010",
               out_valid, out, flags);
    end
    drive(1'b0, 1'b0, OP_HLT, 8'h00, 8'h00, 1'b1);
    total++;
    if ({out_valid, out, flags} !== {1'b1, 8'h5A, 4'b1000}) begin
      bad++;
      $display("FAIL lda_zero: got v=%0b out=%h flags=%b want v=1 out=5a flags=1000",
               out_valid, out, flags);
    end
  endtask

  task automatic test_back_pressure();
    opcode_t     ops [6] = '{OP_XOR, OP_AND, OP_ADD, OP_HLT, OP_STO, OP_JMP};
    logic [7:0]  as  [6] = '{8'hA5, 8'hF0, 8'h80, 8'h00, 8'h81, 8'h00};
    logic [7:0]  ds  [6] = '{8'h0F, 8'h3C, 8'h80, 8'h77, 8'h00, 8'h12};
    logic [11:0] exp [6] = '{{8'hAA, 4'b0100}, {8'h30, 4'b0000}, {8'h00, 4'b0011},
                             {8'h00, 4'b1000}, {8'h81, 4'b0100}, {8'h00, 4'b1000}};
    int sent = 0;
    int got = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      logic ordy;
      ordy = !(cyc >= 2 && cyc <= 4);
      if (sent < 6) drive(1'b0, 1'b1, ops[sent], as[sent], ds[sent], ordy);
      else          drive(1'b0, 1'b0, OP_HLT, 8'h00, 8'h00, ordy);
      if (cyc >= 2 && cyc <= 4) begin
        total++;
        if ({in_ready, out_valid, out} !== {1'b0, 1'b1, 8'hAA}) begin
          bad++;
          $display("FAIL bp_stall cyc%0d: got rdy=%0b v=%0b out=%h want rdy=0 v=1 out=aa",
                   cyc, in_ready, out_valid, out);
        end
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        total++;
        if (got >= 6) begin
          bad++;
          $display("FAIL bp_extra: got extra beat out=%h want none", out);
        end else if ({out, flags} !== exp[got]) begin
          bad++;
          $display("FAIL bp_beat%0d: got %h want %h", got, {out, flags}, exp[got]);
        end
        got++;
      end
    end
    total++;
    if (got !== 6) begin
      bad++;
      $display("FAIL bp_count: got %0d results want 6", got);
    end
  endtask

  task automatic test_random();
    logic [11:0] exp_q [$];
    logic [11:0] e;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      drive(1'b0, $urandom_range(0, 3) != 0, opcode_t'(3'($urandom_range(0, 7))),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            $urandom_range(0, 3) != 0);
      if (in_valid && in_ready) exp_q.push_back(ref_beat(opcode, accum, data));
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rand_extra: got %h want no beat", {out, flags});
        end else begin
          e = exp_q.pop_front();
          if ({out, flags} !== e) begin
            bad++;
            $display("FAIL rand_beat cyc%0d: got %h want %h", cyc, {out, flags}, e);
          end
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, OP_HLT, 8'h00, 8'h00, 1'b1);
      if (out_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rand_drain_extra: got %h want no beat", {out, flags});
        end else begin
          e = exp_q.pop_front();
          if ({out, flags} !== e) begin
            bad++;
            $display("FAIL rand_drain: got %h want %h", {out, flags}, e);
          end
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL rand_lost: got %0d beats missing want 0", exp_q.size());
    end
  endtask

  task automatic test_param_sweep();
    int          lat_exp [6] = '{1, 4, 1, 4, 1, 4};
    logic [31:0] out_exp [6] = '{32'h8, 32'h8, 32'h8000, 32'h8000,
                                 32'h8000_0000, 32'h8000_0000};
    int          seen [6] = '{-1, -1, -1, -1, -1, -1};
    logic [31:0] cap_out [6];
    alu_flags_t  cap_fl [6];
    @(posedge clk);
    #1;
    sw_valid = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 6; g++) begin
      total++;
      if (sw_ir[g] !== 1'b1) begin
        bad++;
        $display("FAIL sweep_ready%0d: got %0b want 1", g, sw_ir[g]);
      end
    end
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      sw_valid = 1'b0;
      @(negedge clk);
      for (int g = 0; g < 6; g++) begin
        if (sw_ov[g] && seen[g] < 0) begin
          seen[g] = c;
          cap_out[g] = sw_out[g];
          cap_fl[g] = sw_fl[g];
        end
      end
    end
    for (int g = 0; g < 6; g++) begin
      total++;
      if (seen[g] != lat_exp[g]) begin
        bad++;
        $display("FAIL sweep_latency%0d: got %0d want %0d", g, seen[g], lat_exp[g]);
      end else if ({cap_out[g], cap_fl[g]} !== {out_exp[g], 4'b0101}) begin
        bad++;
        $display("FAIL sweep_result%0d: got out=%h flags=%b want out=%h flags=0101",
                 g, cap_out[g], cap_fl[g], out_exp[g]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_ovf();
    test_carry_lda();
    test_back_pressure();
    test_random();
    test_param_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
